// File: rtl/viterbi_pkg.sv
// Shared defaults and helpers for the Viterbi path-metric store.
package viterbi_pkg;

  localparam int DEF_METRIC_W    = 12;
  localparam int DEF_ACS_PER_SEG = 4;
  localparam int DEF_SEGMENTS    = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // Callers zero-extend into 32 bits and truncate back, keeping this width-agnostic.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : 32'd0;
  endfunction

endpackage

// File: rtl/viterbi_metric_bank.sv
// One metric bank: single write port, registered read of an even/odd word pair.
module viterbi_metric_bank #(
  parameter int WORD_W   = 48,
  parameter int SEGMENTS = 16,
  parameter int SEG_AW   = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [SEG_AW-1:0]     waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  input  logic [SEG_AW-2:0]     raddr,
  output logic [2*WORD_W-1:0]   rdata
);

  logic [WORD_W-1:0] mem [SEGMENTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= {mem[{raddr, 1'b1}], mem[{raddr, 1'b0}]};
  end

endmodule

// File: rtl/viterbi_metric_ram.sv
// Ping-pong path-metric store: bank swap on Hold, min tracking, read normalisation
// and step-integrity checking.
module viterbi_metric_ram
  import viterbi_pkg::*;
#(
  parameter int METRIC_W    = DEF_METRIC_W,
  parameter int ACS_PER_SEG = DEF_ACS_PER_SEG,
  parameter int SEGMENTS    = DEF_SEGMENTS,
  localparam int SEG_AW     = clog2(SEGMENTS),
  localparam int WORD_W     = ACS_PER_SEG * METRIC_W
) (
  input  logic                  Clock2,
  input  logic                  Reset,
  input  logic                  Hold,
  input  logic [SEG_AW-1:0]     ACSSegment,
  input  logic [WORD_W-1:0]     Metric,
  input  logic                  MetricValid,
  input  logic                  ReadEnable,
  output logic [2*WORD_W-1:0]   PathMetric,
  output logic                  PathMetricValid,
  output logic                  MMBlockSelect,
  output logic [METRIC_W-1:0]   NormOffset,
  output logic                  StepError
);

  localparam int CNT_W = SEG_AW + 1;

  logic [2*WORD_W-1:0] bank_rdata [2];
  logic [1:0]          bank_valid;
  logic [CNT_W-1:0]    write_count, count_next;
  logic [METRIC_W-1:0] min_metric, min_next;
  logic                rd_ok, rd_sel;
  logic [METRIC_W-1:0] rd_off;
  logic                rd_bank;

  assign rd_bank = ~MMBlockSelect;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    viterbi_metric_bank #(
      .WORD_W   (WORD_W),
      .SEGMENTS (SEGMENTS),
      .SEG_AW   (SEG_AW)
    ) u_bank (
      .clk   (Clock2),
      .we    (MetricValid && (MMBlockSelect == 1'(b))),
      .waddr (ACSSegment),
      .wdata (Metric),
      .re    (ReadEnable && (MMBlockSelect != 1'(b))),
      .raddr (ACSSegment[SEG_AW-1:1]),
      .rdata (bank_rdata[b])
    );
  end

  // Running min and count including this cycle's write, so Hold sees the closing step whole.
  always_comb begin
    min_next   = min_metric;
    count_next = write_count;
    if (MetricValid) begin
      for (int i = 0; i < ACS_PER_SEG; i++) begin
        if (Metric[i*METRIC_W +: METRIC_W] < min_next) min_next = Metric[i*METRIC_W +: METRIC_W];
      end
      if (write_count != CNT_W'(SEGMENTS)) count_next = write_count + 1'b1;
    end
  end

  always_ff @(posedge Clock2) begin
    if (!Reset) begin
      MMBlockSelect   <= 1'b0;
      PathMetricValid <= 1'b0;
      NormOffset      <= '0;
      StepError       <= 1'b0;
      bank_valid      <= '0;
      write_count     <= '0;
      min_metric      <= '1;
      rd_ok           <= 1'b0;
      rd_sel          <= 1'b0;
      rd_off          <= '0;
    end else begin
      PathMetricValid <= ReadEnable;
      if (ReadEnable) begin
        rd_ok  <= bank_valid[rd_bank];
        rd_sel <= rd_bank;
        rd_off <= NormOffset;
      end
      if (Hold) begin
        MMBlockSelect             <= ~MMBlockSelect;
        bank_valid[MMBlockSelect] <= 1'b1;
        NormOffset                <= (count_next == '0) ? '0 : min_next;
        min_metric                <= '1;
        write_count               <= '0;
        if (count_next != CNT_W'(SEGMENTS)) StepError <= 1'b1;
      end else begin
        min_metric  <= min_next;
        write_count <= count_next;
      end
    end
  end

  // Normalisation sits after the bank register; rd_ok masks data from a never-written bank.
  always_comb begin
    PathMetric = '0;
    if (rd_ok) begin
      for (int j = 0; j < 2*ACS_PER_SEG; j++) begin
        PathMetric[j*METRIC_W +: METRIC_W] =
          METRIC_W'(sat_sub(32'(bank_rdata[rd_sel][j*METRIC_W +: METRIC_W]), 32'(rd_off)));
      end
    end
  end

endmodule

// File: tb/tb_viterbi_metric_ram.sv
// Directed bench for viterbi_metric_ram with hand-computed expectations.
module tb_viterbi_metric_ram;

  logic        Clock2;
  logic        Reset;
  logic        Hold;
  logic [3:0]  ACSSegment;
  logic [47:0] Metric;
  logic        MetricValid;
  logic        ReadEnable;
  logic [95:0] PathMetric;
  logic        PathMetricValid;
  logic        MMBlockSelect;
  logic [11:0] NormOffset;
  logic        StepError;

  int checks = 0;
  int errors = 0;

  viterbi_metric_ram dut (
    .Clock2          (Clock2),
    .Reset           (Reset),
    .Hold            (Hold),
    .ACSSegment      (ACSSegment),
    .Metric          (Metric),
    .MetricValid     (MetricValid),
    .ReadEnable      (ReadEnable),
    .PathMetric      (PathMetric),
    .PathMetricValid (PathMetricValid),
    .MMBlockSelect   (MMBlockSelect),
    .NormOffset      (NormOffset),
    .StepError       (StepError)
  );

  initial Clock2 = 1'b0;
  always #5 Clock2 = ~Clock2;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock2);
    #1;
  endtask

  task automatic wr(input int seg, input logic [11:0] v);
    ACSSegment  = 4'(seg);
    Metric      = {4{v}};
    MetricValid = 1'b1;
    tick();
    MetricValid = 1'b0;
  endtask

  task automatic rd(input int seg);
    ACSSegment = 4'(seg);
    ReadEnable = 1'b1;
    tick();
    ReadEnable = 1'b0;
  endtask

  task automatic hold();
    Hold = 1'b1;
    tick();
    Hold = 1'b0;
  endtask

  function automatic logic [95:0] pm(input logic [11:0] hi, input logic [11:0] lo);
    return {{4{hi}}, {4{lo}}};
  endfunction

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; Hold = 1'b0; ACSSegment = '0; Metric = '0;
    MetricValid = 1'b0; ReadEnable = 1'b0;
    tick(); tick();
    Reset = 1'b1;

    check("rst_sel",  MMBlockSelect, 1'b0);
    check("rst_norm", NormOffset, 12'd0);
    check("rst_err",  StepError, 1'b0);
    check("rst_pmv",  PathMetricValid, 1'b0);
    check("rst_pm",   PathMetric, 96'd0);

    // Read from a never-written bank
    rd(4);
    check("t1_pmv", PathMetricValid, 1'b1);
    check("t1_pm",  PathMetric, 96'd0);
    check("t1_err", StepError, 1'b0);
    check("t1_sel", MMBlockSelect, 1'b0);
    tick();
    check("t1_pmv_pulse", PathMetricValid, 1'b0);

    // Full step into bank 0, offset 100
    for (int s = 0; s < 16; s++) wr(s, 12'(100 + s));
    hold();
    check("t2_sel",  MMBlockSelect, 1'b1);
    check("t2_norm", NormOffset, 12'd100);
    check("t2_err",  StepError, 1'b0);
    rd(6);
    check("t2_pm6", PathMetric, pm(12'd7, 12'd6));
    check("t2_pmv", PathMetricValid, 1'b1);
    ReadEnable = 1'b1;
    ACSSegment = 4'd0;
    tick();
    check("t2_b2b_a", PathMetric, pm(12'd1, 12'd0));
    ACSSegment = 4'd14;
    tick();
    check("t2_b2b_b", PathMetric, pm(12'd15, 12'd14));
    check("t2_b2b_pmv", PathMetricValid, 1'b1);
    ReadEnable = 1'b0;

    // Bank 1 with min 0x050 at seg 0
    for (int s = 0; s < 16; s++) wr(s, 12'(12'h050 + 3 * s));
    hold();
    check("t3_sel",  MMBlockSelect, 1'b0);
    check("t3_norm", NormOffset, 12'h050);
    rd(0);
    check("t3_pm0", PathMetric, pm(12'd3, 12'd0));
    for (int s = 0; s < 16; s++) wr(s, 12'h020);
    // Hold together with a read: read must see pre-swap bank 1 and offset 0x050
    ACSSegment = 4'd2;
    ReadEnable = 1'b1;
    Hold = 1'b1;
    tick();
    Hold = 1'b0;
    ReadEnable = 1'b0;
    check("t3_hold_rd", PathMetric, pm(12'd9, 12'd6));
    check("t3_norm2",   NormOffset, 12'h020);
    check("t3_sel2",    MMBlockSelect, 1'b1);
    check("t3_err",     StepError, 1'b0);

    // Short step sets sticky error
    for (int s = 0; s < 15; s++) wr(s, 12'h030);
    hold();
    check("t4_err",  StepError, 1'b1);
    check("t4_norm", NormOffset, 12'h030);
    for (int s = 0; s < 16; s++) wr(s, 12'h040);
    hold();
    check("t4_err_sticky", StepError, 1'b1);
    check("t4_norm2",      NormOffset, 12'h040);

    do_reset();
    check("t4_rst_err", StepError, 1'b0);
    check("t4_rst_sel", MMBlockSelect, 1'b0);

    // Last write coincides with Hold
    for (int s = 0; s < 15; s++) wr(s, 12'(20 + s));
    ACSSegment  = 4'd15;
    Metric      = {4{12'd7}};
    MetricValid = 1'b1;
    Hold        = 1'b1;
    tick();
    MetricValid = 1'b0;
    Hold        = 1'b0;
    check("t5_err",  StepError, 1'b0);
    check("t5_norm", NormOffset, 12'd7);
    check("t5_sel",  MMBlockSelect, 1'b1);
    rd(15);
    check("t5_pm15", PathMetric, pm(12'd0, 12'd27));

    // Mid-step reset
    wr(0, 12'd5);
    wr(1, 12'd6);
    do_reset();
    check("t6_sel",  MMBlockSelect, 1'b0);
    check("t6_norm", NormOffset, 12'd0);
    check("t6_err",  StepError, 1'b0);
    check("t6_pmv",  PathMetricValid, 1'b0);
    check("t6_pm",   PathMetric, 96'd0);
    rd(0);
    check("t6_rd_inv", PathMetric, 96'd0);
    check("t6_rd_pmv", PathMetricValid, 1'b1);
    for (int s = 0; s < 16; s++) wr(s, 12'(12'h010 + s));
    rd(2);
    check("t6_rd_inv2", PathMetric, 96'd0);
    hold();
    check("t6_norm2", NormOffset, 12'h010);
    rd(2);
    check("t6_pm2", PathMetric, pm(12'd3, 12'd2));

    // Zero-write step with a concurrent read
    ACSSegment = 4'd4;
    ReadEnable = 1'b1;
    Hold = 1'b1;
    tick();
    Hold = 1'b0;
    ReadEnable = 1'b0;
    check("t7_pm",   PathMetric, pm(12'd5, 12'd4));
    check("t7_sel",  MMBlockSelect, 1'b0);
    check("t7_norm", NormOffset, 12'd0);
    check("t7_err",  StepError, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
